// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC/IR registers, next-PC selection and a timed IDLE/FETCH handshake with imem.
// Optional build macro IU_ALIGN_CHECK_EN rejects fetches from a misaligned PC with fetch_err.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_ld,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] reg_in,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    output logic [31:0] pc_out,
    output logic [31:0] ir_out,
    output logic [31:0] se16,
    output logic [4:0]  s_addr,
    output logic [4:0]  t_addr,
    output logic [4:0]  d_addr,
    output logic [4:0]  shamt,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   pc_ld_val_s;

    assign se16   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign s_addr = ir_q[25:21];
    assign t_addr = ir_q[20:16];
    assign d_addr = ir_q[15:11];
    assign shamt  = ir_q[10:6];

    assign pc_out     = pc_q;
    assign ir_out     = ir_q;
    assign busy       = (state_q == S_FETCH);
    assign imem_rd    = (state_q == S_FETCH);
    assign fetch_done = done_q;
    assign fetch_err  = err_q;
`ifdef IU_ALIGN_CHECK_EN
    assign imem_addr  = pc_q;
`else
    assign imem_addr  = {pc_q[31:2], 2'b00};
`endif

    // Candidate PC for a pc_ld strobe, selected by pc_sel.
    always_comb begin
        pc_ld_val_s = pc_q + 32'd4;
        case (pc_sel)
            2'b00:   pc_ld_val_s = pc_q + 32'd4;
            2'b01:   pc_ld_val_s = pc_q + {se16[29:0], 2'b00};
            2'b10:   pc_ld_val_s = {pc_q[31:28], ir_q[25:0], 2'b00};
            2'b11:   pc_ld_val_s = reg_in;
            default: pc_ld_val_s = pc_q + 32'd4;
        endcase
    end

    // Next-state logic; in IDLE a pc_ld takes effect before the fetch so the fetch sees the new PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pc_ld) begin
                    pc_d = pc_ld_val_s;
                end else begin
                    pc_d = pc_q;
                end
                if (fetch_req) begin
`ifdef IU_ALIGN_CHECK_EN
                    if (pc_d[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end
`else
                    state_d = S_FETCH;
                    wait_d  = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_IDLE;
                    wait_d  = '0;
                    done_d  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
            wait_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter WAIT_LIMIT, default 16, maximum number of FETCH cycles allowed without imem_ack.
REQ-003 Port clk  in  1  on-board clock; the block SHALL use this single clock.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port fetch_req  in  1  control unit request to fetch the word at PC into IR.
REQ-006 Port pc_ld  in  1  PC load strobe, qualified by pc_sel.
REQ-007 Port pc_sel  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump, 11 reg_in.
REQ-008 Port reg_in  in  32  register-sourced target for jr/return, taken from the datapath ALU_OUT.
REQ-009 Port imem_data  in  32  instruction memory read data.
REQ-010 Port imem_ack  in  1  instruction memory data-valid.
REQ-011 Port imem_addr  out  32  fetch address.
REQ-012 Port imem_rd  out  1  fetch strobe.
REQ-013 Port pc_out  out  32  current PC; feeds the datapath pc_in.
REQ-014 Port ir_out  out  32  instruction register.
REQ-015 Port se16  out  32  sign-extended IR[15:0]; feeds the datapath DT.
REQ-016 Port s_addr, t_addr, d_addr, shamt  out  5 each  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
REQ-017 Port busy  out  1  high while in FETCH.
REQ-018 Port fetch_done  out  1  one-cycle pulse after IR is loaded.
REQ-019 Port fetch_err  out  1  one-cycle pulse on timeout or misalignment.

Function
REQ-020 The FSM SHALL have two states, IDLE and FETCH; busy = (state==FETCH).
REQ-021 In IDLE with fetch_req=1, the block SHALL enter FETCH on the next edge.
REQ-022 In FETCH, imem_rd SHALL be 1 and imem_addr SHALL equal PC; otherwise imem_rd=0.
REQ-023 On FETCH with imem_ack=1, the block SHALL latch IR<=imem_data and PC<=PC+4, return to IDLE, and pulse fetch_done in the following cycle.
REQ-024 The wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack.
REQ-025 When the wait counter reaches WAIT_LIMIT-1 without ack, the block SHALL return to IDLE, pulse fetch_err next cycle, and leave IR and PC unchanged.
REQ-026 In IDLE, pc_ld=1 SHALL load PC from: 00 PC+4; 01 PC+(se16<<2); 10 {PC[31:28],IR[25:0],2'b00}; 11 reg_in.
REQ-027 pc_ld in FETCH SHALL be ignored.
REQ-028 If fetch_req and pc_ld are both asserted in IDLE, the PC SHALL update first, and the fetch SHALL use the new PC.
REQ-029 fetch_req in FETCH SHALL be ignored and not queued.
REQ-030 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-031 se16, s_addr, t_addr, d_addr and shamt SHALL be combinational decodes of IR.

Reset
REQ-032 On reset the block SHALL set PC=RESET_PC, IR=0, state=IDLE, wait counter=0, and fetch_done=fetch_err=imem_rd=busy=0.
REQ-033 Reset asserted mid-FETCH SHALL abort the fetch immediately, and a later imem_ack SHALL be ignored.

Configuration
REQ-034 With IU_ALIGN_CHECK_EN defined, fetch_req in IDLE with PC[1:0]!=0 SHALL NOT enter FETCH; it SHALL pulse fetch_err next cycle and leave IR and PC unchanged.
REQ-035 Without IU_ALIGN_CHECK_EN, imem_addr SHALL be {PC[31:2],2'b00} and no misalignment error SHALL exist.

Verification
REQ-036 Reset, then fetch_req with ack after 2 cycles and imem_data=32'h2108_0004 -> ir_out=32'h2108_0004, pc_out=4, fetch_done one pulse, se16=32'h0000_0004.
REQ-037 IR=32'h1000_FFFF, PC=8, pc_ld with pc_sel=01 -> PC=32'h0000_0004.
REQ-038 IR=32'h0800_0010, PC=32'h4000_0000, pc_sel=10 -> PC=32'h4000_0040; then reg_in=32'h100, pc_sel=11 -> PC=32'h100.
REQ-039 fetch_req with no ack -> fetch_err pulse after 16 FETCH cycles, PC and IR unchanged, busy low afterwards.
REQ-040 Reset asserted during FETCH, then imem_ack -> PC=RESET_PC, IR=0, no fetch_done.
REQ-041 With IU_ALIGN_CHECK_EN and PC=32'h2 after reg_in load -> fetch_req gives fetch_err, imem_rd never high.
